// File: rtl/gpio_wb_pkg.sv
// Shared definitions for the GPIO Wishbone initiator: FSM states, register field
// offsets and the set/clear word packing used by the GPIO peripheral.
package gpio_wb_pkg;

    localparam int unsigned IN_LSB  = 16;
    localparam int unsigned OUT_LSB = 0;

    typedef enum logic [2:0] {
        IDLE,
        WR_REQ,
        WR_ACK,
        RD_REQ,
        RD_ACK
    } state_t;

    // Upper half selects the bits to change, lower half carries their new values.
    function automatic logic [31:0] pack_cmd(input logic [15:0] mask, input logic [15:0] value);
        return {mask, mask & value};
    endfunction

endpackage

// File: rtl/gpio_wbmaster.sv
// Wishbone pipelined initiator for a set/clear GPIO register: turns a command stream
// into masked writes and services the peripheral's change interrupt with read-backs.
module gpio_wbmaster
    import gpio_wb_pkg::*;
#(
    parameter int unsigned NIN     = 16,
    parameter int unsigned NOUT    = 16,
    parameter int unsigned AW      = 30,
    parameter int unsigned ADDR    = 0,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic            i_clk,
    input  logic            i_reset,
    input  logic            i_cmd_valid,
    output logic            o_cmd_ready,
    input  logic [NOUT-1:0] i_cmd_mask,
    input  logic [NOUT-1:0] i_cmd_value,
    input  logic            i_int,
    output logic            o_wb_cyc,
    output logic            o_wb_stb,
    output logic            o_wb_we,
    output logic [AW-1:0]   o_wb_addr,
    output logic [31:0]     o_wb_data,
    input  logic            i_wb_stall,
    input  logic            i_wb_ack,
    input  logic            i_wb_err,
    input  logic [31:0]     i_wb_data,
    output logic            o_in_valid,
    output logic [NIN-1:0]  o_in_data,
    output logic [NOUT-1:0] o_out_data,
    output logic            o_err
);

    localparam int unsigned CW = $clog2(TIMEOUT + 1);

    state_t        state;
    logic          pend;
    logic [CW-1:0] cnt;

    logic in_ack;
    logic cmd_fire;
    logic bus_err;
    logic timed_out;
    logic abort;
    logic ack_done;
    logic rd_fail;
    logic rd_accept;
    logic pend_nxt;

    assign o_wb_addr = AW'(ADDR);

    // Transaction termination and pending-read bookkeeping; a set always beats a clear.
    always_comb begin
        in_ack    = (state == WR_ACK) || (state == RD_ACK);
        cmd_fire  = i_cmd_valid && o_cmd_ready;
        bus_err   = i_wb_err && o_wb_cyc;
        timed_out = in_ack && !i_wb_ack && (cnt == CW'(TIMEOUT - 1));
        abort     = bus_err || timed_out;
        ack_done  = in_ack && i_wb_ack && !abort;
        rd_fail   = abort && ((state == RD_REQ) || (state == RD_ACK));
        rd_accept = (state == RD_REQ) && !i_wb_stall;
        pend_nxt  = pend;
        if (rd_accept)
            pend_nxt = 1'b0;
        if (i_int || rd_fail)
            pend_nxt = 1'b1;
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state       <= IDLE;
            pend        <= 1'b1;
            cnt         <= '0;
            o_cmd_ready <= 1'b0;
            o_wb_cyc    <= 1'b0;
            o_wb_stb    <= 1'b0;
            o_wb_we     <= 1'b0;
            o_wb_data   <= '0;
            o_in_valid  <= 1'b0;
            o_in_data   <= '0;
            o_out_data  <= '0;
            o_err       <= 1'b0;
        end else begin
            pend       <= pend_nxt;
            o_in_valid <= 1'b0;
            o_err      <= 1'b0;
            if (abort || ack_done) begin
                // Every transaction ends here, leaving cyc low for at least one cycle.
                state       <= IDLE;
                o_wb_cyc    <= 1'b0;
                o_wb_stb    <= 1'b0;
                o_wb_we     <= 1'b0;
                o_cmd_ready <= !pend_nxt;
                o_err       <= abort;
                if (ack_done && (state == RD_ACK)) begin
                    o_in_valid <= 1'b1;
                    o_in_data  <= i_wb_data[IN_LSB +: NIN];
                    o_out_data <= i_wb_data[OUT_LSB +: NOUT];
                end
            end else begin
                unique case (state)
                    IDLE: begin
                        cnt <= '0;
                        if (pend) begin
                            state       <= RD_REQ;
                            o_wb_cyc    <= 1'b1;
                            o_wb_stb    <= 1'b1;
                            o_wb_we     <= 1'b0;
                            o_cmd_ready <= 1'b0;
                        end else if (cmd_fire) begin
                            state       <= WR_REQ;
                            o_wb_cyc    <= 1'b1;
                            o_wb_stb    <= 1'b1;
                            o_wb_we     <= 1'b1;
                            o_wb_data   <= pack_cmd(16'(i_cmd_mask), 16'(i_cmd_value));
                            o_cmd_ready <= 1'b0;
                        end else begin
                            o_cmd_ready <= !pend_nxt;
                        end
                    end
                    WR_REQ, RD_REQ: begin
                        if (!i_wb_stall) begin
                            state    <= (state == WR_REQ) ? WR_ACK : RD_ACK;
                            o_wb_stb <= 1'b0;
                            cnt      <= '0;
                        end
                    end
                    WR_ACK, RD_ACK: begin
                        cnt <= cnt + CW'(1);
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule
